// File: rtl/sha256_pkg.sv
// sha256_pkg: shared state encoding, block geometry and counter widths for the SHA-256 controller.
package sha256_pkg;
    localparam int BLOCK_BYTES  = 64;
    localparam int ROUNDS       = 64;
    localparam int DIGEST_BYTES = 32;
    localparam int BYTE_CNT_W   = $clog2(BLOCK_BYTES);
    localparam int ROUND_CNT_W  = $clog2(ROUNDS);
    localparam int OUT_CNT_W    = $clog2(DIGEST_BYTES);
    typedef enum logic [2:0] {LOAD, INIT, ROUND, ADD, OUT} state_t;
endpackage

// File: rtl/sha256_byte_packer.sv
// sha256_byte_packer: packs accepted message bytes big-endian into 32-bit words for the W schedule.
module sha256_byte_packer
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        accept,
    input  logic [7:0]  data,
    input  logic        word_end,
    output logic [31:0] w_word,
    output logic        w_load
);
    logic [23:0] shift;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            shift  <= '0;
            w_word <= '0;
            w_load <= 1'b0;
        end else begin
            w_load <= accept & word_end;
            if (accept) shift <= {shift[15:0], data};
            if (accept & word_end) w_word <= {shift, data};
        end
endmodule

// File: rtl/sha256_ctrl.sv
// sha256_ctrl: sequences byte load, a..h init, 64 rounds and H accumulate on the SHA-256 datapath,
// then serializes the digest after the final block.
module sha256_ctrl
    import sha256_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    input  logic                   in_init,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [7:0]             out_data,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   dp_h_iv,
    output logic                   dp_w_load,
    output logic [31:0]            dp_w_word,
    output logic                   dp_init_ab,
    output logic                   dp_round_en,
    output logic [ROUND_CNT_W-1:0] dp_round,
    output logic                   dp_h_add,
    input  logic [255:0]           dp_digest
);
    state_t                 state;
    logic [BYTE_CNT_W-1:0]  byte_cnt;
    logic [ROUND_CNT_W-1:0] round_cnt;
    logic [OUT_CNT_W-1:0]   out_cnt;
    logic                   last_q;
    logic                   accept;
    assign accept   = in_valid & in_ready;
    assign dp_h_iv  = accept & in_init & (byte_cnt == '0) & ~rst;
    assign dp_round = round_cnt;
    // byte k of the digest starts at bit 255-8k, i.e. {~k, 3'b111}
    assign out_data = out_valid ? dp_digest[{~out_cnt, 3'b111} -: 8] : 8'h00;
    sha256_byte_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .accept   (accept),
        .data     (in_data),
        .word_end (byte_cnt[1:0] == 2'b11),
        .w_word   (dp_w_word),
        .w_load   (dp_w_load)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state       <= LOAD;
            byte_cnt    <= '0;
            round_cnt   <= '0;
            out_cnt     <= '0;
            last_q      <= 1'b0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            dp_init_ab  <= 1'b0;
            dp_round_en <= 1'b0;
            dp_h_add    <= 1'b0;
        end else begin
            dp_init_ab <= 1'b0;
            dp_h_add   <= 1'b0;
            case (state)
                LOAD: if (accept) begin
                    busy <= 1'b1;
                    if (byte_cnt == BYTE_CNT_W'(BLOCK_BYTES - 1)) begin
                        state      <= INIT;
                        byte_cnt   <= '0;
                        last_q     <= in_last;
                        in_ready   <= 1'b0;
                        dp_init_ab <= 1'b1;
                    end else byte_cnt <= byte_cnt + 1'b1;
                end
                INIT: begin
                    state       <= ROUND;
                    round_cnt   <= '0;
                    dp_round_en <= 1'b1;
                end
                ROUND: if (round_cnt == ROUND_CNT_W'(ROUNDS - 1)) begin
                    state       <= ADD;
                    round_cnt   <= '0;
                    dp_round_en <= 1'b0;
                    dp_h_add    <= 1'b1;
                end else round_cnt <= round_cnt + 1'b1;
                ADD: begin
                    state     <= last_q ? OUT : LOAD;
                    out_valid <= last_q;
                    in_ready  <= ~last_q;
                    busy      <= last_q;
                end
                OUT: if (out_ready) begin
                    if (out_cnt == OUT_CNT_W'(DIGEST_BYTES - 1)) begin
                        state     <= LOAD;
                        out_cnt   <= '0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        last_q    <= 1'b0;
                    end else out_cnt <= out_cnt + 1'b1;
                end
                default: state <= LOAD;
            endcase
        end
endmodule

// File: tb/tb_sha256_ctrl.sv
// tb_sha256_ctrl: drives padded blocks into sha256_ctrl with a behavioural SHA-256 datapath attached,
// scoreboarding assembled words and digest bytes against known answers.
module tb_sha256_ctrl;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [7:0]   in_data = 8'h00;
    logic         in_init = 1'b0;
    logic         in_last = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [7:0]   out_data;
    logic         out_ready = 1'b1;
    logic         busy;
    logic         dp_h_iv;
    logic         dp_w_load;
    logic [31:0]  dp_w_word;
    logic         dp_init_ab;
    logic         dp_round_en;
    logic [5:0]   dp_round;
    logic         dp_h_add;
    logic [255:0] dp_digest;

    sha256_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_init(in_init),
        .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .busy(busy), .dp_h_iv(dp_h_iv), .dp_w_load(dp_w_load),
        .dp_w_word(dp_w_word), .dp_init_ab(dp_init_ab), .dp_round_en(dp_round_en),
        .dp_round(dp_round), .dp_h_add(dp_h_add), .dp_digest(dp_digest)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [31:0] IV [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                       32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [255:0] ABC_DIG = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] TWO_DIG = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    localparam logic [63:0]  B0  = 64'h0000_0000_0000_0001;
    localparam logic [63:0]  B63 = 64'h8000_0000_0000_0000;

    int checks = 0;
    int errors = 0;
    int hiv_cnt = 0;
    logic [31:0] wq [$];
    logic [7:0]  dq [$];
    logic [7:0]  blk [64];

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction
    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction
    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    // behavioural datapath: acts on the strobes the controller presents in each cycle
    logic [31:0] hm [8];
    logic [31:0] v [8];
    logic [31:0] w [64];
    logic [31:0] t1, t2;
    int widx = 0;
    assign dp_digest = {hm[0], hm[1], hm[2], hm[3], hm[4], hm[5], hm[6], hm[7]};
    always @(negedge clk) begin
        if (rst) widx = 0;
        else begin
            if (dp_h_iv) for (int i = 0; i < 8; i++) hm[i] = IV[i];
            if (dp_w_load && widx < 16) begin
                w[widx] = dp_w_word;
                widx++;
            end
            if (dp_init_ab) begin
                for (int t = 16; t < 64; t++) w[t] = ssig1(w[t-2]) + w[t-7] + ssig0(w[t-15]) + w[t-16];
                for (int i = 0; i < 8; i++) v[i] = hm[i];
                widx = 0;
            end
            if (dp_round_en) begin
                t1 = v[7] + bsig1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[dp_round] + w[dp_round];
                t2 = bsig0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
                for (int i = 7; i > 0; i--) v[i] = v[i-1];
                v[4] = v[4] + t1;
                v[0] = t1 + t2;
            end
            if (dp_h_add) for (int i = 0; i < 8; i++) hm[i] = hm[i] + v[i];
        end
    end

    // scoreboard pop side: words on dp_w_load, digest bytes on the output handshake
    logic [31:0] exp_w;
    logic [7:0]  exp_b;
    always @(negedge clk) if (!rst) begin
        if (dp_h_iv) hiv_cnt++;
        if (dp_w_load) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL w_word: got unexpected load %h, required no load", dp_w_word);
            end else begin
                exp_w = wq.pop_front();
                if (dp_w_word !== exp_w) begin
                    errors++;
                    $display("FAIL w_word: got %h, required %h", dp_w_word, exp_w);
                end
            end
        end
        if (out_valid && out_ready) begin
            checks++;
            if (dq.size() == 0) begin
                errors++;
                $display("FAIL digest_byte: got unexpected byte %h, required none", out_data);
            end else begin
                exp_b = dq.pop_front();
                if (out_data !== exp_b) begin
                    errors++;
                    $display("FAIL digest_byte: got %h, required %h", out_data, exp_b);
                end
            end
        end
    end

    task automatic fill_abc();
        for (int i = 0; i < 64; i++) blk[i] = 8'h00;
        blk[0] = 8'h61; blk[1] = 8'h62; blk[2] = 8'h63; blk[3] = 8'h80; blk[63] = 8'h18;
    endtask

    task automatic fill_two(input int part);
        string s = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        for (int i = 0; i < 64; i++) blk[i] = 8'h00;
        if (part == 0) begin
            for (int i = 0; i < 56; i++) blk[i] = s[i];
            blk[56] = 8'h80;
        end else begin
            blk[62] = 8'h01;
            blk[63] = 8'hc0;
        end
    endtask

    // returns just after the edge that accepts byte 63
    task automatic send_block(input logic [63:0] init_mask, input logic [63:0] last_mask,
                              input bit rnd, input logic [255:0] dig);
        int i = 0;
        int guard = 0;
        @(posedge clk); #1;
        while (i < 64) begin
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = blk[i];
            in_init  = init_mask[i];
            in_last  = last_mask[i];
            @(negedge clk);
            if (in_valid && in_ready) begin
                if (i % 4 == 3) wq.push_back({blk[i-3], blk[i-2], blk[i-1], blk[i]});
                if (i == 63 && last_mask[63]) for (int k = 0; k < 32; k++) dq.push_back(dig[255-8*k -: 8]);
                if (i < 63) begin
                    checks++;
                    if (dp_init_ab !== 1'b0 || out_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL early_exit: byte %0d init_ab=%b out_valid=%b, required 0 0", i, dp_init_ab, out_valid);
                    end
                end
                i++;
            end
            guard++;
            if (guard > 2000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: byte %0d not accepted, required acceptance within 2000 cycles", i);
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_init  = 1'b0;
        in_last  = 1'b0;
    endtask

    // cycle c after the byte-63 edge: c=0 INIT, 1..64 rounds, 65 ADD, 66 OUT or LOAD
    task automatic check_sequence(input bit last, input bit junk);
        logic [10:0] got, exp;
        logic        en;
        for (int c = 0; c <= 66; c++) begin
            in_valid = junk && c < 65;
            in_data  = 8'hee;
            @(negedge clk);
            en  = c >= 1 && c <= 64;
            exp = {c == 0, en, en ? 6'(c - 1) : 6'd0, c == 65, last && c == 66, !last && c == 66};
            got = {dp_init_ab, dp_round_en, dp_round_en ? dp_round : 6'd0, dp_h_add, out_valid, in_ready};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL sequence: cycle %0d {init,en,round,add,ov,ir} got %b, required %b", c, got, exp);
            end
            if (c < 66) begin
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit found = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (in_ready && !busy && !out_valid) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s_idle: in_ready=%b busy=%b out_valid=%b, required 1 0 0", name, in_ready, busy, out_valid);
        end
    endtask

    task automatic check_done(input string name, input int exp_hiv);
        checks++;
        if (hiv_cnt != exp_hiv) begin
            errors++;
            $display("FAIL %s_h_iv: got %0d pulses, required %0d", name, hiv_cnt, exp_hiv);
        end
        checks++;
        if (dq.size() != 0 || wq.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: got %0d bytes %0d words pending, required 0 0", name, dq.size(), wq.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_busy: got %b %b, required 1 0", in_ready, busy);
        end
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_out: got valid=%b data=%h, required 0 00", out_valid, out_data);
        end
        checks++;
        if ({dp_h_iv, dp_w_load, dp_init_ab, dp_round_en, dp_h_add} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b, required 00000", {dp_h_iv, dp_w_load, dp_init_ab, dp_round_en, dp_h_add});
        end
        checks++;
        if (dp_w_word !== 32'h0 || dp_round !== 6'd0) begin
            errors++;
            $display("FAIL reset_word_round: got %h %0d, required 0 0", dp_w_word, dp_round);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got %b %b, required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_abc();
        hiv_cnt = 0;
        fill_abc();
        send_block(B0, B63, 0, ABC_DIG);
        check_sequence(1, 0);
        wait_idle("abc");
        check_done("abc", 1);
    endtask

    task automatic test_two_block();
        hiv_cnt = 0;
        fill_two(0);
        send_block(B0, 64'h0, 0, 256'h0);
        check_sequence(0, 0);
        fill_two(1);
        send_block(64'h0, B63, 0, TWO_DIG);
        check_sequence(1, 0);
        wait_idle("two_block");
        check_done("two_block", 1);
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        hiv_cnt = 0;
        out_ready = 1'b0;
        fill_abc();
        send_block(B0, B63, 1, ABC_DIG);
        check_sequence(1, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b0;
        held = dq[0];
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== held) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d valid=%b data=%h, required 1 %h", c, out_valid, out_data, held);
            end
        end
        out_ready = 1'b1;
        wait_idle("backpressure");
        check_done("backpressure", 1);
    endtask

    task automatic test_ignore_flags();
        hiv_cnt = 0;
        fill_abc();
        send_block(64'h20, 64'h400, 0, 256'h0);
        check_sequence(0, 0);
        check_done("ignore_flags", 0);
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        logic [13:0] got;
        hiv_cnt = 0;
        fill_abc();
        send_block(B0, B63, 0, ABC_DIG);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (dp_round_en && dp_round == 6'd30) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reach_round30: round 30 not seen, required within 100 cycles");
        end
        #2 rst = 1'b1;
        #1;
        got = {in_ready, busy, out_valid, dp_init_ab, dp_round_en, dp_h_add, dp_w_load, dp_h_iv, dp_round};
        checks++;
        if (got !== 14'b10000000_000000) begin
            errors++;
            $display("FAIL mid_reset: {ir,busy,ov,init,en,add,wl,iv,round} got %b, required %b", got, 14'b10000000_000000);
        end
        dq.delete();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        hiv_cnt = 0;
        send_block(B0, B63, 0, ABC_DIG);
        check_sequence(1, 0);
        wait_idle("reset_mid");
        check_done("reset_mid", 1);
    endtask

    initial begin
        test_reset();
        test_abc();
        test_two_block();
        test_backpressure();
        test_ignore_flags();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
